// File: rtl/game_board.sv
// Board storage and move judge for the 3x3 game: accepts cell writes from the
// controller, then spends one cycle scoring the registered board for a line or a tie.
module game_board #(
    parameter bit ALLOW_OVERWRITE = 1'b0,
    parameter bit TIE_DETECT      = 1'b1
) (
    input  logic        ph1,
    input  logic        reset_n,
    input  logic        newGame,
    input  logic [3:0]  addr,
    input  logic [1:0]  cellState,
    output logic [17:0] gBoard,
    output logic        gameIsDone,
    output logic [1:0]  winner,
    output logic [3:0]  moveCount,
    output logic        writeAck,
    output logic        writeErr
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [1:0]  winner_q, winner_d;
    logic        done_q, done_d;
    logic [3:0]  count_q, count_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [1:0]  cells [16];
    logic [17:0] write_mask;
    logic        write_req, write_ok;
    logic        p1_line, p2_line;

    // Address 0 and 10..15 map to a padding entry so the cell lookup is always in range.
    for (genvar g = 0; g < 16; g++) begin : g_cell
        if (g >= 1 && g <= 9) begin : g_valid
            assign cells[g] = board_q[2*g-1 -: 2];
            assign write_mask[2*g-1 -: 2] = {2{addr == 4'(g)}};
        end else begin : g_pad
            assign cells[g] = 2'b00;
        end
    end

    function automatic logic line_any(input logic [17:0] b, input logic [1:0] p);
        logic [1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
        c1 = b[1:0];   c2 = b[3:2];   c3 = b[5:4];
        c4 = b[7:6];   c5 = b[9:8];   c6 = b[11:10];
        c7 = b[13:12]; c8 = b[15:14]; c9 = b[17:16];
        return ((c1 == p) && (c2 == p) && (c3 == p)) ||
               ((c4 == p) && (c5 == p) && (c6 == p)) ||
               ((c7 == p) && (c8 == p) && (c9 == p)) ||
               ((c1 == p) && (c4 == p) && (c7 == p)) ||
               ((c2 == p) && (c5 == p) && (c8 == p)) ||
               ((c3 == p) && (c6 == p) && (c9 == p)) ||
               ((c1 == p) && (c5 == p) && (c9 == p)) ||
               ((c3 == p) && (c5 == p) && (c7 == p));
    endfunction

    assign write_req = (addr != 4'd0);
    assign write_ok  = (addr <= 4'd9) && cellState[1] &&
                       ((cells[addr] == 2'b00) || ALLOW_OVERWRITE);
    assign p1_line   = line_any(board_q, 2'b11);
    assign p2_line   = line_any(board_q, 2'b10);

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        winner_d = winner_q;
        done_d   = done_q;
        count_d  = count_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        if (newGame) begin
            state_d  = IDLE;
            board_d  = '0;
            winner_d = 2'b00;
            done_d   = 1'b0;
            count_d  = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (write_req) begin
                        if (write_ok) begin
                            board_d = (board_q & ~write_mask) | ({9{cellState}} & write_mask);
                            ack_d   = 1'b1;
                            state_d = CHECK;
                            if (cells[addr] == 2'b00 && count_q < 4'd9) begin
                                count_d = count_q + 4'd1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    err_d   = write_req;
                    state_d = IDLE;
                    // Player1 is tested first so a double line (only reachable via overwrite) goes to player1.
                    if (p1_line) begin
                        winner_d = 2'b11;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (p2_line) begin
                        winner_d = 2'b10;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (TIE_DETECT && count_q == 4'd9) begin
                        winner_d = 2'b01;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    err_d = write_req;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            board_q  <= '0;
            winner_q <= 2'b00;
            done_q   <= 1'b0;
            count_q  <= 4'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            winner_q <= winner_d;
            done_q   <= done_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign gBoard     = board_q;
    assign gameIsDone = done_q;
    assign winner     = winner_q;
    assign moveCount  = count_q;
    assign writeAck   = ack_q;
    assign writeErr   = err_q;

endmodule

// File: tb/tb_game_board.sv
// Directed, table-driven bench for game_board: each record is one clock of
// stimulus with the outputs expected just after that edge.
module tb_game_board;

    logic        ph1 = 1'b0;
    logic        reset_n;
    logic        newGame;
    logic [3:0]  addr;
    logic [1:0]  cellState;
    logic [17:0] gBoard;
    logic        gameIsDone;
    logic [1:0]  winner;
    logic [3:0]  moveCount;
    logic        writeAck;
    logic        writeErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ng;
        logic [3:0]  a;
        logic [1:0]  cs;
        logic [17:0] expBoard;
        logic        expDone;
        logic [1:0]  expWinner;
        logic [3:0]  expCount;
        logic        expAck;
        logic        expErr;
    } vector_t;

    vector_t vecs[$];

    always #5 ph1 = ~ph1;

    game_board #(
        .ALLOW_OVERWRITE(1'b0),
        .TIE_DETECT     (1'b1)
    ) dut (
        .ph1       (ph1),
        .reset_n   (reset_n),
        .newGame   (newGame),
        .addr      (addr),
        .cellState (cellState),
        .gBoard    (gBoard),
        .gameIsDone(gameIsDone),
        .winner    (winner),
        .moveCount (moveCount),
        .writeAck  (writeAck),
        .writeErr  (writeErr)
    );

    function automatic logic [17:0] cellBits(input int k, input logic [1:0] code);
        return 18'(code) << (2 * (k - 1));
    endfunction

    function automatic void addVec(input logic ng, input logic [3:0] a, input logic [1:0] cs,
                                   input logic [17:0] b, input logic d, input logic [1:0] w,
                                   input logic [3:0] c, input logic ak, input logic er);
        vector_t v;
        v.ng = ng; v.a = a; v.cs = cs;
        v.expBoard = b; v.expDone = d; v.expWinner = w;
        v.expCount = c; v.expAck = ak; v.expErr = er;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [17:0] b, input logic d,
                            input logic [1:0] w, input logic [3:0] c, input logic ak, input logic er);
        checkOutput({tag, " gBoard"}, gBoard, b);
        checkOutput({tag, " gameIsDone"}, 18'(gameIsDone), 18'(d));
        checkOutput({tag, " winner"}, 18'(winner), 18'(w));
        checkOutput({tag, " moveCount"}, 18'(moveCount), 18'(c));
        checkOutput({tag, " writeAck"}, 18'(writeAck), 18'(ak));
        checkOutput({tag, " writeErr"}, 18'(writeErr), 18'(er));
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic applyStimulus(input logic ng, input logic [3:0] a, input logic [1:0] cs);
        newGame   = ng;
        addr      = a;
        cellState = cs;
        @(posedge ph1);
        #1;
        newGame   = 1'b0;
        addr      = 4'd0;
        cellState = 2'b00;
    endtask

    initial begin
        logic [17:0] b;
        int          tieCells [9];
        logic [1:0]  code;

        // Single write, then the scoring cycle finds nothing.
        b = cellBits(5, 2'b11);
        addVec(0, 4'd5, 2'b11, b, 0, 2'b00, 4'd1, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd1, 0, 0);

        // Player1 row 1-2-3 versus player2 at 4 and 5.
        addVec(1, 4'd0, 2'b00, 18'd0, 0, 2'b00, 4'd0, 0, 0);
        b = cellBits(1, 2'b11);
        addVec(0, 4'd1, 2'b11, b, 0, 2'b00, 4'd1, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd1, 0, 0);
        b |= cellBits(4, 2'b10);
        addVec(0, 4'd4, 2'b10, b, 0, 2'b00, 4'd2, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd2, 0, 0);
        b |= cellBits(2, 2'b11);
        addVec(0, 4'd2, 2'b11, b, 0, 2'b00, 4'd3, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd3, 0, 0);
        b |= cellBits(5, 2'b10);
        addVec(0, 4'd5, 2'b10, b, 0, 2'b00, 4'd4, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd4, 0, 0);
        b |= cellBits(3, 2'b11);
        addVec(0, 4'd3, 2'b11, b, 0, 2'b00, 4'd5, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 1, 2'b11, 4'd5, 0, 0);
        addVec(0, 4'd9, 2'b10, b, 1, 2'b11, 4'd5, 0, 1);
        addVec(0, 4'd0, 2'b00, b, 1, 2'b11, 4'd5, 0, 0);

        // Full board with no line: X X O / O O X / X O X.
        addVec(1, 4'd0, 2'b00, 18'd0, 0, 2'b00, 4'd0, 0, 0);
        tieCells = '{1, 3, 2, 4, 6, 5, 7, 8, 9};
        b = 18'd0;
        for (int i = 0; i < 9; i++) begin
            code = (i % 2 == 0) ? 2'b11 : 2'b10;
            b |= cellBits(tieCells[i], code);
            addVec(0, 4'(tieCells[i]), code, b, 0, 2'b00, 4'(i + 1), 1, 0);
            if (i == 8) addVec(0, 4'd0, 2'b00, b, 1, 2'b01, 4'd9, 0, 0);
            else        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'(i + 1), 0, 0);
        end

        // Rejections: occupied cell, bad address, bad codes.
        addVec(1, 4'd0, 2'b00, 18'd0, 0, 2'b00, 4'd0, 0, 0);
        b = cellBits(5, 2'b10);
        addVec(0, 4'd5, 2'b10, b, 0, 2'b00, 4'd1, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd1, 0, 0);
        addVec(0, 4'd5, 2'b10, b, 0, 2'b00, 4'd1, 0, 1);
        addVec(0, 4'd12, 2'b11, b, 0, 2'b00, 4'd1, 0, 1);
        addVec(0, 4'd1, 2'b01, b, 0, 2'b00, 4'd1, 0, 1);
        addVec(0, 4'd1, 2'b00, b, 0, 2'b00, 4'd1, 0, 1);

        // Write arriving during the scoring cycle is refused, retry succeeds.
        b |= cellBits(2, 2'b11);
        addVec(0, 4'd2, 2'b11, b, 0, 2'b00, 4'd2, 1, 0);
        addVec(0, 4'd7, 2'b11, b, 0, 2'b00, 4'd2, 0, 1);
        b |= cellBits(7, 2'b11);
        addVec(0, 4'd7, 2'b11, b, 0, 2'b00, 4'd3, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd3, 0, 0);

        // Player2 diagonal 3-5-7, then newGame wins over a simultaneous write.
        addVec(1, 4'd0, 2'b00, 18'd0, 0, 2'b00, 4'd0, 0, 0);
        b = cellBits(3, 2'b10);
        addVec(0, 4'd3, 2'b10, b, 0, 2'b00, 4'd1, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd1, 0, 0);
        b |= cellBits(1, 2'b11);
        addVec(0, 4'd1, 2'b11, b, 0, 2'b00, 4'd2, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd2, 0, 0);
        b |= cellBits(5, 2'b10);
        addVec(0, 4'd5, 2'b10, b, 0, 2'b00, 4'd3, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd3, 0, 0);
        b |= cellBits(2, 2'b11);
        addVec(0, 4'd2, 2'b11, b, 0, 2'b00, 4'd4, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 0, 2'b00, 4'd4, 0, 0);
        b |= cellBits(7, 2'b10);
        addVec(0, 4'd7, 2'b10, b, 0, 2'b00, 4'd5, 1, 0);
        addVec(0, 4'd0, 2'b00, b, 1, 2'b10, 4'd5, 0, 0);
        addVec(1, 4'd1, 2'b11, 18'd0, 0, 2'b00, 4'd0, 0, 0);

        reset_n   = 1'b0;
        newGame   = 1'b0;
        addr      = 4'd0;
        cellState = 2'b00;
        #2;
        checkAll("reset", 18'd0, 0, 2'b00, 4'd0, 0, 0);
        @(negedge ph1);
        @(negedge ph1);
        reset_n = 1'b1;
        @(posedge ph1);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ng, vecs[i].a, vecs[i].cs);
            checkAll($sformatf("vec%0d", i), vecs[i].expBoard, vecs[i].expDone,
                     vecs[i].expWinner, vecs[i].expCount, vecs[i].expAck, vecs[i].expErr);
        end

        // Asynchronous reset landing in the middle of a scoring cycle.
        applyStimulus(1'b0, 4'd9, 2'b11);
        checkAll("preReset", cellBits(9, 2'b11), 0, 2'b00, 4'd1, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkAll("midCheckReset", 18'd0, 0, 2'b00, 4'd0, 0, 0);
        @(negedge ph1);
        reset_n = 1'b1;
        @(posedge ph1);
        #1;
        applyStimulus(1'b0, 4'd9, 2'b10);
        checkAll("postReset", cellBits(9, 2'b10), 0, 2'b00, 4'd1, 1, 0);
        applyStimulus(1'b0, 4'd0, 2'b00);
        checkAll("postResetIdle", cellBits(9, 2'b10), 0, 2'b00, 4'd1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_board.md
Name: game_board

Overview:
- Storage and judging end of the board-write interface driven by the game controller.
- Accepts cell writes as a cell address (addr) plus a cell code (cellState), and holds the 3x3 board as the packed vector gBoard.
- Checks every accepted move for a line or a full board. Returns gameIsDone and winner to the controller.

Parameters:
- ALLOW_OVERWRITE, 0, 1 lets a write replace an occupied cell; 0 rejects writes to occupied cells.
- TIE_DETECT, 1, 1 declares a tie (winner 01) when 9 moves have no line; 0 leaves winner 00 and gameIsDone low on a full board.

Ports:
- ph1  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- newGame  input  1  synchronous clear of board, counters and result.
- addr  input  4  cell address, 1..9 valid; 0 means no write.
- cellState  input  2  code to write: 11 = player1, 10 = player2.
- gBoard  output  18  cell k (1..9) at bits [2k-1:2k-2]; rows are 1-2-3, 4-5-6, 7-8-9.
- gameIsDone  output  1  high from the result cycle until newGame or reset.
- winner  output  2  11 = player1, 10 = player2, 01 = tie, 00 = none.
- moveCount  output  4  number of accepted moves, 0..9.
- writeAck  output  1  one-cycle pulse: the write was accepted.
- writeErr  output  1  one-cycle pulse: the write was rejected.

Behaviour:
- Clock and reset:
  - One clock, ph1. Reset is asynchronous and active-low (reset_n).
  - Under reset: gBoard=0, gameIsDone=0, winner=00, moveCount=0, writeAck=0, writeErr=0, state=IDLE.
- Write request: any cycle with addr != 0.
- States: IDLE, CHECK, DONE.
- IDLE, valid write (addr in 1..9, cellState in {11,10}, target cell 00 or ALLOW_OVERWRITE=1):
  - At the edge: store the cell, pulse writeAck, go to CHECK.
  - moveCount increments only when the target cell was 00.
- IDLE, invalid write (addr 10..15, cellState 00/01, or occupied cell with ALLOW_OVERWRITE=0):
  - Pulse writeErr. Board is unchanged. Stay in IDLE.
- CHECK: one cycle. Evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on the registered gBoard.
  - A line of 11 gives winner=11. A line of 10 gives winner=10.
  - If both players have a line (possible only with overwrites), player1 takes priority.
  - No line, moveCount=9 and TIE_DETECT=1: winner=01.
  - Any result: gameIsDone=1 and go to DONE. Otherwise go to IDLE.
  - A write request arriving in CHECK is rejected with writeErr.
- Latency:
  - gBoard updates on the edge that accepts the write.
  - winner and gameIsDone update on the next edge.
  - The controller sees gameIsDone two edges after presenting addr.
- DONE:
  - Every write is rejected with writeErr.
  - Outputs hold until newGame or reset_n.
- newGame:
  - Synchronous. Highest priority over any write in the same cycle.
  - Clears gBoard, winner, gameIsDone and moveCount, and returns to IDLE.
  - Produces no writeAck and no writeErr that cycle.
- writeAck and writeErr are never high together. Each is high for exactly one cycle per request cycle.
- Multiple lines by the same player in one move: winner is set once with no special handling.
- Asynchronous reset during CHECK or DONE: immediate return to reset values. A pending evaluation is discarded.
- moveCount saturates at 9. An overwrite never changes it.

Test Plan:
- Reset, then addr=5/cellState=11 for one cycle -> writeAck=1; gBoard[9:8]=11; moveCount=1; next cycle winner=00, gameIsDone=0.
- Player1 takes cells 1,2,3 and player2 takes 4,5, alternating, each followed by one idle cycle -> after the write to cell 3, gBoard updates on that edge; winner=11 and gameIsDone=1 one edge later; a further write to 9 -> writeErr=1, gBoard unchanged.
- Fill the board with no line (11 at 1,2,6,7,9; 10 at 3,4,5,8) -> after the 9th write, winner=01, gameIsDone=1, moveCount=9.
- Write 10 to cell 5 twice with ALLOW_OVERWRITE=0 -> second write gives writeErr=1 and moveCount stays 1. Write addr=12 -> writeErr=1. Write cellState=01 -> writeErr=1.
- Write to cell 7 in the cycle right after an accepted write (CHECK state) -> writeErr=1; the same write retried one cycle later -> writeAck=1.
- Player2 completes diagonal 3-5-7, then newGame=1 together with addr=1 -> gBoard=0, winner=00, moveCount=0, no ack and no err. Then drop reset_n in the middle of a CHECK cycle -> all outputs 0 immediately.
